trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
Trap/return sequencer for the machine-mode CSR file. It accepts ecall, ebreak, mret and machine timer/external interrupts at instruction commit. It serialises the resulting mepc, mcause and mstatus updates through the CSR file's single write port, then issues a one-cycle PC redirect. When idle it passes the core's CSR-instruction writes straight through, so it also arbitrates that write port.

Parameters:
XLEN, 64, data/PC width; mcause interrupt flag is bit XLEN-1.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-low reset
exec_valid  in  1  instruction at commit stage valid this cycle
inst_is_x  in  3  001 ebreak, 010 ecall, 100 mret, others none
irq_timer  in  1  machine timer interrupt pending (level)
irq_ext  in  1  machine external interrupt pending (level)
pc  in  XLEN  PC of committing instruction
mstatus_i  in  XLEN  current mstatus read value
mtvec_i  in  XLEN  current mtvec read value
mepc_i  in  XLEN  current mepc read value
core_csr_wen  in  1  core CSR instruction write request
core_csr_idx  in  12  core CSR address
core_csr_wdata  in  XLEN  core CSR write data
csr_wen  out  1  CSR write-port enable
csr_idx  out  12  CSR write-port address
csr_wdata  out  XLEN  CSR write-port data
stall  out  1  hold fetch/commit
redirect_valid  out  1  one-cycle PC redirect strobe
redirect_pc  out  XLEN  redirect target

Behaviour:
- States: IDLE, T_EPC, T_CAUSE, T_STATUS, R_STATUS, JUMP. Registers: state, saved pc, cause, interrupt flag, mstatus snapshot, target.
- Reset (rst=0 at edge): state=IDLE, all internal registers 0. All outputs 0, since outputs decode from the registers. Reset mid-sequence aborts it; partial CSR writes are not undone.
- Accept in IDLE when exec_valid=1. Priority: irq_ext (only if mstatus_i[3]=1) > irq_timer (only if mstatus_i[3]=1) > ecall > ebreak > mret.
- Cause codes: irq_ext = {1,…,11}; irq_timer = {1,…,7}; ecall = 11; ebreak = 3.
- On accept, latch pc and mstatus_i. A trap goes to T_EPC; mret goes to R_STATUS.
- stall = (state != IDLE) | accept. This is combinational, so it is high in the accept cycle.
- IDLE, no accept: csr_wen/idx/wdata = core_* pass-through.
- IDLE with accept: core write is dropped and csr_wen=0.
- Non-IDLE states: core_* ignored. New requests and interrupts are ignored, with no queuing.
- T_EPC: write 0x341 with the latched pc (address of the instruction not completed).
- T_CAUSE: write 0x342 with the cause.
- T_STATUS: write 0x300 with the snapshot modified as follows: bit7 (MPIE) = snapshot bit3, bit3 (MIE) = 0, bits12:11 (MPP) = 2'b11. All other bits unchanged.
- Trap target, computed in T_STATUS: base = mtvec_i with [1:0] cleared. If mtvec_i[1:0]=01 and the trap is an interrupt, target = base + 4*code (mod 2^XLEN). Otherwise target = base.
- R_STATUS: write 0x300 with the snapshot modified as follows: bit3 = snapshot bit7, bit7 = 1, MPP = 11. Target = mepc_i.
- JUMP: redirect_valid=1, redirect_pc=target, csr_wen=0, stall=1; next state IDLE. redirect_pc is 0 whenever redirect_valid=0.
- Latency, accept at cycle T (edge at end of T):
  - Trap: mepc write in T+1, mcause in T+2, mstatus in T+3, redirect in T+4, stall low from T+5.
  - mret: mstatus write in T+1, redirect in T+2.
- Exactly one CSR write per busy cycle. csr_idx and csr_wdata are 0 when csr_wen=0 outside IDLE.

Test Plan:
1. mstatus_i=0x1808, mtvec_i=0x80001000, ecall at pc=0x80000010. Required response:
   - 0x341←0x80000010 (T+1), 0x342←11 (T+2), 0x300←0x1880 (T+3).
   - redirect_pc=0x80001000 at T+4; stall high T..T+4.
2. mtvec_i=0x80001001 (vectored), mstatus_i MIE=1, irq_timer=1 with simultaneous ebreak. Required response:
   - Interrupt wins: mcause=0x8000000000000007.
   - redirect_pc=0x8000101C.
3. Same interrupt with MIE=0 and ebreak pending. Required response: mcause=3, redirect_pc=0x80001000.
4. mret, mstatus_i=0x1880, mepc_i=0x80000014. Required response:
   - 0x300←0x1888 at T+1.
   - redirect_pc=0x80000014 at T+2; stall low at T+3.
5. Idle core write 0x340←0xDEAD passes through same cycle. A core write during T_CAUSE is not forwarded, and the T_CAUSE write is unchanged.
6. rst=0 asserted during T_CAUSE. Required response: next cycle all outputs 0, state IDLE, and no redirect is issued.

Source files
------------

// File: rtl/trap_ctrl.sv
// Machine-mode trap/return sequencer. It serialises mepc/mcause/mstatus updates
// through the single CSR write port, then issues a one-cycle PC redirect.
module trap_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exec_valid,
  input  logic [2:0]      inst_is_x,
  input  logic            irq_timer,
  input  logic            irq_ext,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic            core_csr_wen,
  input  logic [11:0]     core_csr_idx,
  input  logic [XLEN-1:0] core_csr_wdata,
  output logic            csr_wen,
  output logic [11:0]     csr_idx,
  output logic [XLEN-1:0] csr_wdata,
  output logic            stall,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_T_EPC    = 3'd1;
  localparam logic [2:0] S_T_CAUSE  = 3'd2;
  localparam logic [2:0] S_T_STATUS = 3'd3;
  localparam logic [2:0] S_R_STATUS = 3'd4;
  localparam logic [2:0] S_JUMP     = 3'd5;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [3:0]      cause_q, cause_d;
  logic            intr_q, intr_d;
  logic [XLEN-1:0] status_q, status_d;
  logic [XLEN-1:0] target_q, target_d;

  logic            take_ext, take_tmr, is_ecall, is_ebreak, is_mret, accept;
  logic [XLEN-1:0] mcause_val, trap_status, ret_status, tvec_base, tvec_off;

  // Interrupts only win when globally enabled; the instruction encodings are one-hot.
  always_comb begin
    take_ext  = exec_valid & mstatus_i[3] & irq_ext;
    take_tmr  = exec_valid & mstatus_i[3] & irq_timer;
    is_ecall  = exec_valid & (inst_is_x == 3'b010);
    is_ebreak = exec_valid & (inst_is_x == 3'b001);
    is_mret   = exec_valid & (inst_is_x == 3'b100);
    accept    = (state_q == S_IDLE) &
                (take_ext | take_tmr | is_ecall | is_ebreak | is_mret);
  end

  always_comb begin
    mcause_val = {intr_q, {(XLEN-5){1'b0}}, cause_q};

    trap_status        = status_q;
    trap_status[7]     = status_q[3];
    trap_status[3]     = 1'b0;
    trap_status[12:11] = 2'b11;

    ret_status         = status_q;
    ret_status[3]      = status_q[7];
    ret_status[7]      = 1'b1;
    ret_status[12:11]  = 2'b11;

    tvec_base = {mtvec_i[XLEN-1:2], 2'b00};
    tvec_off  = {{(XLEN-6){1'b0}}, cause_q, 2'b00};
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    cause_d        = cause_q;
    intr_d         = intr_q;
    status_d       = status_q;
    target_d       = target_q;
    csr_wen        = 1'b0;
    csr_idx        = 12'h000;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stall          = (state_q != S_IDLE) | accept;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          pc_d     = pc;
          status_d = mstatus_i;
          state_d  = S_T_EPC;
          if (take_ext) begin
            intr_d  = 1'b1;
            cause_d = 4'd11;
          end else if (take_tmr) begin
            intr_d  = 1'b1;
            cause_d = 4'd7;
          end else if (is_ecall) begin
            intr_d  = 1'b0;
            cause_d = 4'd11;
          end else if (is_ebreak) begin
            intr_d  = 1'b0;
            cause_d = 4'd3;
          end else begin
            intr_d  = 1'b0;
            cause_d = 4'd0;
            state_d = S_R_STATUS;
          end
        end else begin
          csr_wen   = core_csr_wen;
          csr_idx   = core_csr_idx;
          csr_wdata = core_csr_wdata;
        end
      end
      S_T_EPC: begin
        csr_wen   = 1'b1;
        csr_idx   = CSR_MEPC;
        csr_wdata = pc_q;
        state_d   = S_T_CAUSE;
      end
      S_T_CAUSE: begin
        csr_wen   = 1'b1;
        csr_idx   = CSR_MCAUSE;
        csr_wdata = mcause_val;
        state_d   = S_T_STATUS;
      end
      S_T_STATUS: begin
        csr_wen   = 1'b1;
        csr_idx   = CSR_MSTATUS;
        csr_wdata = trap_status;
        // Vectored mode offsets only interrupts; exceptions always land on the base.
        if ((mtvec_i[1:0] == 2'b01) && intr_q) begin
          target_d = tvec_base + tvec_off;
        end else begin
          target_d = tvec_base;
        end
        state_d   = S_JUMP;
      end
      S_R_STATUS: begin
        csr_wen   = 1'b1;
        csr_idx   = CSR_MSTATUS;
        csr_wdata = ret_status;
        target_d  = mepc_i;
        state_d   = S_JUMP;
      end
      S_JUMP: begin
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
        state_d        = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      cause_q  <= '0;
      intr_q   <= 1'b0;
      status_q <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cause_q  <= cause_d;
      intr_q   <= intr_d;
      status_q <= status_d;
      target_q <= target_d;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized
// sequences checked against a cycle-list reference model.
module tb_trap_ctrl;

  localparam int XLEN = 64;

  typedef logic [142:0] vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            exec_valid = 1'b0;
  logic [2:0]      inst_is_x = 3'b000;
  logic            irq_timer = 1'b0;
  logic            irq_ext = 1'b0;
  logic [XLEN-1:0] pc = '0;
  logic [XLEN-1:0] mstatus_i = '0;
  logic [XLEN-1:0] mtvec_i = '0;
  logic [XLEN-1:0] mepc_i = '0;
  logic            core_csr_wen = 1'b0;
  logic [11:0]     core_csr_idx = 12'h000;
  logic [XLEN-1:0] core_csr_wdata = '0;
  logic            csr_wen;
  logic [11:0]     csr_idx;
  logic [XLEN-1:0] csr_wdata;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  int   checks = 0;
  int   errors = 0;
  vec_t obs   [0:5];
  vec_t exp_v [0:5];
  int   exp_len;

  trap_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .exec_valid(exec_valid), .inst_is_x(inst_is_x),
    .irq_timer(irq_timer), .irq_ext(irq_ext),
    .pc(pc), .mstatus_i(mstatus_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .core_csr_wen(core_csr_wen), .core_csr_idx(core_csr_idx), .core_csr_wdata(core_csr_wdata),
    .csr_wen(csr_wen), .csr_idx(csr_idx), .csr_wdata(csr_wdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete (got timeout, required finish)");
    $fatal(1, "[TB] watchdog expired");
  end

  // Packed view of every output: {wen, idx, wdata, stall, redirect_valid, redirect_pc}.
  function automatic vec_t pack(input logic wen, input logic [11:0] idx, input logic [63:0] d,
                                input logic st, input logic rv, input logic [63:0] rpc);
    return {wen, idx, d, st, rv, rpc};
  endfunction

  function automatic vec_t observed();
    return pack(csr_wen, csr_idx, csr_wdata, stall, redirect_valid, redirect_pc);
  endfunction

  function automatic vec_t busy_only();
    return pack(1'b0, 12'h000, 64'h0, 1'b1, 1'b0, 64'h0);
  endfunction

  function automatic vec_t all_zero();
    return pack(1'b0, 12'h000, 64'h0, 1'b0, 1'b0, 64'h0);
  endfunction

  // Reference: lists the outputs expected from the accept cycle until the redirect.
  function automatic void model(input logic ev, input logic [2:0] inst, input logic ti,
                                input logic ei, input logic [63:0] ms, input logic [63:0] tv,
                                input logic [63:0] ep, input logic [63:0] p,
                                input logic cw, input logic [11:0] ci, input logic [63:0] cd);
    int          kind;
    bit          intr;
    int          code;
    logic [63:0] mcause, st, target;
    kind = 0;
    intr = 0;
    code = 0;
    if (ev) begin
      if (ms[3] && ei)        begin kind = 1; intr = 1; code = 11; end
      else if (ms[3] && ti)   begin kind = 1; intr = 1; code = 7;  end
      else if (inst == 3'd2)  begin kind = 1; code = 11; end
      else if (inst == 3'd1)  begin kind = 1; code = 3;  end
      else if (inst == 3'd4)  begin kind = 2; end
    end
    if (kind == 0) begin
      exp_v[0] = pack(cw, ci, cd, 1'b0, 1'b0, 64'h0);
      exp_len  = 1;
    end else if (kind == 1) begin
      mcause = intr ? (64'h8000_0000_0000_0000 + 64'(code)) : 64'(code);
      st = ms;
      st[7] = ms[3];
      st[3] = 1'b0;
      st[12:11] = 2'b11;
      target = tv - (tv % 64'd4);
      if ((tv % 64'd4) == 64'd1 && intr) target = target + 64'(4 * code);
      exp_v[0] = busy_only();
      exp_v[1] = pack(1'b1, 12'h341, p, 1'b1, 1'b0, 64'h0);
      exp_v[2] = pack(1'b1, 12'h342, mcause, 1'b1, 1'b0, 64'h0);
      exp_v[3] = pack(1'b1, 12'h300, st, 1'b1, 1'b0, 64'h0);
      exp_v[4] = pack(1'b0, 12'h000, 64'h0, 1'b1, 1'b1, target);
      exp_len  = 5;
    end else begin
      st = ms;
      st[3] = ms[7];
      st[7] = 1'b1;
      st[12:11] = 2'b11;
      exp_v[0] = busy_only();
      exp_v[1] = pack(1'b1, 12'h300, st, 1'b1, 1'b0, 64'h0);
      exp_v[2] = pack(1'b0, 12'h000, 64'h0, 1'b1, 1'b1, ep);
      exp_len  = 3;
    end
  endfunction

  task automatic quiet_inputs();
    exec_valid     = 1'b0;
    inst_is_x      = 3'b000;
    irq_timer      = 1'b0;
    irq_ext        = 1'b0;
    core_csr_wen   = 1'b0;
    core_csr_idx   = 12'h000;
    core_csr_wdata = '0;
  endtask

  // Drives one committing request, then five quiet cycles, recording outputs T..T+5.
  task automatic run_collect(input logic [2:0] inst, input logic ti, input logic ei,
                             input logic [63:0] ms, input logic [63:0] tv,
                             input logic [63:0] ep, input logic [63:0] p);
    @(negedge clk);
    exec_valid = 1'b1;
    inst_is_x  = inst;
    irq_timer  = ti;
    irq_ext    = ei;
    mstatus_i  = ms;
    mtvec_i    = tv;
    mepc_i     = ep;
    pc         = p;
    #1 obs[0] = observed();
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      quiet_inputs();
      #1 obs[i] = observed();
    end
  endtask

  task automatic test_reset();
    quiet_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (observed() !== all_zero()) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h required %h", observed(), all_zero());
    end
  endtask

  task automatic test_ecall();
    vec_t e [0:5];
    run_collect(3'b010, 1'b0, 1'b0, 64'h1808, 64'h8000_1000, 64'h0, 64'h8000_0010);
    e[0] = busy_only();
    e[1] = pack(1'b1, 12'h341, 64'h8000_0010, 1'b1, 1'b0, 64'h0);
    e[2] = pack(1'b1, 12'h342, 64'd11, 1'b1, 1'b0, 64'h0);
    e[3] = pack(1'b1, 12'h300, 64'h1880, 1'b1, 1'b0, 64'h0);
    e[4] = pack(1'b0, 12'h000, 64'h0, 1'b1, 1'b1, 64'h8000_1000);
    e[5] = all_zero();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs[i] !== e[i]) begin
        errors++;
        $display("[TB] FAIL ecall_cycle_T+%0d: got %h required %h", i, obs[i], e[i]);
      end
    end
  endtask

  task automatic test_irq_vectored();
    vec_t e2, e4;
    run_collect(3'b001, 1'b1, 1'b0, 64'h8, 64'h8000_1001, 64'h0, 64'h8000_0020);
    e2 = pack(1'b1, 12'h342, 64'h8000_0000_0000_0007, 1'b1, 1'b0, 64'h0);
    e4 = pack(1'b0, 12'h000, 64'h0, 1'b1, 1'b1, 64'h8000_101C);
    checks++;
    if (obs[2] !== e2) begin
      errors++;
      $display("[TB] FAIL irq_vec_mcause: got %h required %h", obs[2], e2);
    end
    checks++;
    if (obs[4] !== e4) begin
      errors++;
      $display("[TB] FAIL irq_vec_redirect: got %h required %h", obs[4], e4);
    end
  endtask

  task automatic test_irq_masked();
    vec_t e2, e3, e4;
    run_collect(3'b001, 1'b1, 1'b1, 64'h0, 64'h8000_1001, 64'h0, 64'h8000_0030);
    e2 = pack(1'b1, 12'h342, 64'd3, 1'b1, 1'b0, 64'h0);
    e3 = pack(1'b1, 12'h300, 64'h1800, 1'b1, 1'b0, 64'h0);
    e4 = pack(1'b0, 12'h000, 64'h0, 1'b1, 1'b1, 64'h8000_1000);
    checks++;
    if (obs[2] !== e2) begin
      errors++;
      $display("[TB] FAIL irq_masked_mcause: got %h required %h", obs[2], e2);
    end
    checks++;
    if (obs[3] !== e3) begin
      errors++;
      $display("[TB] FAIL irq_masked_mstatus: got %h required %h", obs[3], e3);
    end
    checks++;
    if (obs[4] !== e4) begin
      errors++;
      $display("[TB] FAIL irq_masked_redirect: got %h required %h", obs[4], e4);
    end
  endtask

  task automatic test_mret();
    vec_t e [0:3];
    run_collect(3'b100, 1'b0, 1'b0, 64'h1880, 64'h8000_1000, 64'h8000_0014, 64'h8000_0040);
    e[0] = busy_only();
    e[1] = pack(1'b1, 12'h300, 64'h1888, 1'b1, 1'b0, 64'h0);
    e[2] = pack(1'b0, 12'h000, 64'h0, 1'b1, 1'b1, 64'h8000_0014);
    e[3] = all_zero();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs[i] !== e[i]) begin
        errors++;
        $display("[TB] FAIL mret_cycle_T+%0d: got %h required %h", i, obs[i], e[i]);
      end
    end
  endtask

  task automatic test_passthrough();
    vec_t e;
    @(negedge clk);
    quiet_inputs();
    core_csr_wen = 1'b1; core_csr_idx = 12'h340; core_csr_wdata = 64'hDEAD;
    #1 e = pack(1'b1, 12'h340, 64'hDEAD, 1'b0, 1'b0, 64'h0);
    checks++;
    if (observed() !== e) begin
      errors++;
      $display("[TB] FAIL idle_passthrough: got %h required %h", observed(), e);
    end
    @(negedge clk);
    exec_valid = 1'b1; inst_is_x = 3'b010; mstatus_i = 64'h1808;
    mtvec_i = 64'h8000_1000; pc = 64'h8000_0050;
    #1 checks++;
    if (observed() !== busy_only()) begin
      errors++;
      $display("[TB] FAIL accept_drops_core: got %h required %h", observed(), busy_only());
    end
    @(negedge clk);
    exec_valid = 1'b0; inst_is_x = 3'b000;
    @(negedge clk);
    core_csr_wdata = 64'hBEEF;
    #1 e = pack(1'b1, 12'h342, 64'd11, 1'b1, 1'b0, 64'h0);
    checks++;
    if (observed() !== e) begin
      errors++;
      $display("[TB] FAIL core_during_t_cause: got %h required %h", observed(), e);
    end
    @(negedge clk);
    quiet_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midseq();
    vec_t e;
    @(negedge clk);
    exec_valid = 1'b1; inst_is_x = 3'b010; mstatus_i = 64'h1808;
    mtvec_i = 64'h8000_1000; pc = 64'h8000_0060;
    @(negedge clk);
    quiet_inputs();
    @(negedge clk);
    rst = 1'b0;
    #1 e = pack(1'b1, 12'h342, 64'd11, 1'b1, 1'b0, 64'h0);
    checks++;
    if (observed() !== e) begin
      errors++;
      $display("[TB] FAIL reset_midseq_t_cause: got %h required %h", observed(), e);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rst = 1'b1;
      #1 checks++;
      if (observed() !== all_zero()) begin
        errors++;
        $display("[TB] FAIL reset_midseq_after_%0d: got %h required %h", i, observed(), all_zero());
      end
    end
  endtask

  task automatic test_random();
    logic        ev, ti, ei, cw;
    logic [2:0]  inst;
    logic [11:0] ci;
    logic [63:0] ms, tv, ep, p, cd;
    for (int n = 0; n < 300; n++) begin
      ev   = ($urandom_range(0, 3) != 0);
      inst = 3'($urandom_range(0, 7));
      ti   = ($urandom_range(0, 3) == 0);
      ei   = ($urandom_range(0, 4) == 0);
      ms   = {$urandom, $urandom};
      tv   = {$urandom, $urandom};
      ep   = {$urandom, $urandom};
      p    = {$urandom, $urandom};
      cw   = 1'($urandom_range(0, 1));
      ci   = 12'($urandom_range(0, 4095));
      cd   = {$urandom, $urandom};
      model(ev, inst, ti, ei, ms, tv, ep, p, cw, ci, cd);
      @(negedge clk);
      exec_valid = ev; inst_is_x = inst; irq_timer = ti; irq_ext = ei;
      mstatus_i = ms; mtvec_i = tv; mepc_i = ep; pc = p;
      core_csr_wen = cw; core_csr_idx = ci; core_csr_wdata = cd;
      #1 checks++;
      if (observed() !== exp_v[0]) begin
        errors++;
        $display("[TB] FAIL random_%0d_accept: got %h required %h", n, observed(), exp_v[0]);
      end
      for (int i = 1; i < exp_len; i++) begin
        @(negedge clk);
        exec_valid = 1'($urandom_range(0, 1));
        inst_is_x  = 3'($urandom_range(0, 7));
        irq_timer  = 1'($urandom_range(0, 1));
        irq_ext    = 1'($urandom_range(0, 1));
        mstatus_i  = {$urandom, $urandom};
        pc         = {$urandom, $urandom};
        core_csr_wen   = 1'($urandom_range(0, 1));
        core_csr_idx   = 12'($urandom_range(0, 4095));
        core_csr_wdata = {$urandom, $urandom};
        #1 checks++;
        if (observed() !== exp_v[i]) begin
          errors++;
          $display("[TB] FAIL random_%0d_busy_%0d: got %h required %h", n, i, observed(), exp_v[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ecall();
    test_irq_vectored();
    test_irq_masked();
    test_mret();
    test_passthrough();
    test_reset_midseq();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
